// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end that time-shares one combinational ALU32Bit
// through a registered issue stage and a registered response stage.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 5,
    parameter int MAX_CTRL   = 29
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Flush,
    input  logic                  Req0Valid,
    output logic                  Req0Ready,
    input  logic [CTRL_WIDTH-1:0] Req0Control,
    input  logic [DATA_WIDTH-1:0] Req0A,
    input  logic [DATA_WIDTH-1:0] Req0B,
    input  logic                  Req1Valid,
    output logic                  Req1Ready,
    input  logic [CTRL_WIDTH-1:0] Req1Control,
    input  logic [DATA_WIDTH-1:0] Req1A,
    input  logic [DATA_WIDTH-1:0] Req1B,
    output logic                  Resp0Valid,
    output logic                  Resp1Valid,
    output logic [DATA_WIDTH-1:0] RespResult,
    output logic                  RespZero,
    output logic                  RespError,
    output logic [CTRL_WIDTH-1:0] AluControl,
    output logic [DATA_WIDTH-1:0] AluA,
    output logic [DATA_WIDTH-1:0] AluB,
    input  logic [DATA_WIDTH-1:0] AluResult,
    input  logic                  AluZero,
    output logic                  Busy
);

    // r_ptr names the requester that wins when both are valid
    logic                  r_ptr;

    logic                  r_iss_valid;
    logic                  r_iss_src;
    logic [CTRL_WIDTH-1:0] r_iss_ctrl;
    logic [DATA_WIDTH-1:0] r_iss_a;
    logic [DATA_WIDTH-1:0] r_iss_b;

    logic                  r_rsp_valid;
    logic                  r_rsp_src;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_rsp_zero;
    logic                  r_rsp_err;

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_accept;
    logic                  w_illegal;

    always_comb begin
        w_grant0 = !Flush && Req0Valid && (!Req1Valid || !r_ptr);
        w_grant1 = !Flush && Req1Valid && (!Req0Valid || r_ptr);
    end

    assign w_accept  = w_grant0 | w_grant1;
    assign w_illegal = r_iss_ctrl > CTRL_WIDTH'(MAX_CTRL);
    assign Req0Ready = w_grant0;
    assign Req1Ready = w_grant1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ptr        <= 1'b0;
            r_iss_valid  <= 1'b0;
            r_iss_src    <= 1'b0;
            r_iss_ctrl   <= '0;
            r_iss_a      <= '0;
            r_iss_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_src    <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else if (Flush) begin
            // Squash both stages; pointer and captured response data are untouched
            r_iss_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_iss_valid <= w_accept;
            if (w_accept) begin
                r_ptr      <= w_grant0;
                r_iss_src  <= w_grant1;
                r_iss_ctrl <= w_grant1 ? Req1Control : Req0Control;
                r_iss_a    <= w_grant1 ? Req1A : Req0A;
                r_iss_b    <= w_grant1 ? Req1B : Req0B;
            end
            r_rsp_valid <= r_iss_valid;
            if (r_iss_valid) begin
                r_rsp_src    <= r_iss_src;
                r_rsp_err    <= w_illegal;
                r_rsp_result <= w_illegal ? '0 : AluResult;
                r_rsp_zero   <= w_illegal ? 1'b1 : AluZero;
            end
        end
    end

    always_comb begin
        AluControl = '0;
        AluA       = '0;
        AluB       = '0;
        if (r_iss_valid) begin
            AluControl = r_iss_ctrl;
            AluA       = r_iss_a;
            AluB       = r_iss_b;
        end
    end

    assign Resp0Valid = r_rsp_valid && !r_rsp_src;
    assign Resp1Valid = r_rsp_valid && r_rsp_src;
    assign RespResult = r_rsp_result;
    assign RespZero   = r_rsp_zero;
    assign RespError  = r_rsp_err;
    assign Busy       = r_iss_valid | r_rsp_valid;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized run against a
// queue-based model; the ALU itself is modelled here.
module tb_alu_share_arbiter;
    localparam int DW   = 32;
    localparam int CW   = 5;
    localparam int MAXC = 29;

    logic          Clk = 1'b0;
    logic          Reset, Flush;
    logic          Req0Valid, Req0Ready, Req1Valid, Req1Ready;
    logic [CW-1:0] Req0Control, Req1Control, AluControl;
    logic [DW-1:0] Req0A, Req0B, Req1A, Req1B, AluA, AluB, AluResult, RespResult;
    logic          Resp0Valid, Resp1Valid, RespZero, RespError, AluZero, Busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    alu_share_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .MAX_CTRL(MAXC)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Control(Req0Control),
        .Req0A(Req0A), .Req0B(Req0B),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Control(Req1Control),
        .Req1A(Req1A), .Req1B(Req1B),
        .Resp0Valid(Resp0Valid), .Resp1Valid(Resp1Valid), .RespResult(RespResult),
        .RespZero(RespZero), .RespError(RespError),
        .AluControl(AluControl), .AluA(AluA), .AluB(AluB),
        .AluResult(AluResult), .AluZero(AluZero), .Busy(Busy)
    );

    // Behavioural ALU: 0 add, 2 sub, 3 or, 4 and, 5 xor, anything else a mixing function
    function automatic logic [DW-1:0] alu_f(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (c)
            5'd0:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a | b;
            5'd4:    return a & b;
            5'd5:    return a ^ b;
            default: return a * 3 + b + DW'(c);
        endcase
    endfunction

    assign AluResult = alu_f(AluControl, AluA, AluB);
    assign AluZero   = (AluResult == '0);

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic set0(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
        Req0Valid = v; Req0Control = c; Req0A = a; Req0B = b;
    endtask

    task automatic set1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
        Req1Valid = v; Req1Control = c; Req1A = a; Req1B = b;
    endtask

    task automatic idle();
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        Flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        @(negedge Clk);
        n_checks++;
        if ({Resp0Valid, Resp1Valid, RespResult, RespZero, RespError, AluControl, AluA, AluB,
             Busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got r0=%b r1=%b res=%h z=%b e=%b ctl=%h a=%h b=%h busy=%b, expected all 0",
                     Resp0Valid, Resp1Valid, RespResult, RespZero, RespError, AluControl,
                     AluA, AluB, Busy);
        end
        Reset = 1'b0;
        @(negedge Clk);
        set0(1'b1, 5'd0, 32'd1, 32'd1);
        set1(1'b1, 5'd0, 32'd2, 32'd2);
        #1;
        n_checks++;
        if ({Req0Ready, Req1Ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_pointer: got ready=%b%b expected 10", Req0Ready, Req1Ready);
        end
        idle();
    endtask

    task automatic test_single();
        do_reset();
        set0(1'b1, 5'd0, 32'h3E8, 32'h112);
        #1;
        n_checks++;
        if ({Req0Ready, Req1Ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_ready: got %b%b expected 10", Req0Ready, Req1Ready);
        end
        cyc();
        idle();
        n_checks++;
        if ({Busy, AluControl, AluA, AluB, Resp0Valid} !== {1'b1, 5'd0, 32'h3E8, 32'h112, 1'b0}) begin
            n_fail++;
            $display("FAIL single_issue: got busy=%b ctl=%h a=%h b=%h r0=%b expected 1 0 3e8 112 0",
                     Busy, AluControl, AluA, AluB, Resp0Valid);
        end
        cyc();
        n_checks++;
        if ({Resp0Valid, Resp1Valid, RespResult, RespZero, RespError} !==
            {1'b1, 1'b0, 32'h4FA, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_resp: got r0=%b r1=%b res=%h z=%b e=%b expected 1 0 4fa 0 0",
                     Resp0Valid, Resp1Valid, RespResult, RespZero, RespError);
        end
        cyc();
        n_checks++;
        if ({Resp0Valid, Busy, RespResult} !== {1'b0, 1'b0, 32'h4FA}) begin
            n_fail++;
            $display("FAIL single_hold: got r0=%b busy=%b res=%h expected 0 0 4fa",
                     Resp0Valid, Busy, RespResult);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set0(i < 4, 5'd0, 32'd7, 32'd8);
            set1(i < 4, 5'd2, 32'd5, 32'd5);
            #1;
            if (i < 4) begin
                n_checks++;
                if ({Req0Ready, Req1Ready} !== {i % 2 == 0, i % 2 == 1}) begin
                    n_fail++;
                    $display("FAIL alt_grant[%0d]: got %b%b", i, Req0Ready, Req1Ready);
                end
            end
            cyc();
            n_checks++;
            if (i >= 1 && i <= 4) begin
                if ({Resp0Valid, Resp1Valid, RespResult, RespZero} !==
                    {(i - 1) % 2 == 0, (i - 1) % 2 == 1,
                     ((i - 1) % 2 == 0) ? 32'd15 : 32'd0, (i - 1) % 2 == 1}) begin
                    n_fail++;
                    $display("FAIL alt_resp[%0d]: got r0=%b r1=%b res=%h z=%b", i, Resp0Valid,
                             Resp1Valid, RespResult, RespZero);
                end
            end else if ({Resp0Valid, Resp1Valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL alt_noresp[%0d]: got %b%b expected 00", i, Resp0Valid, Resp1Valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] ops  [3];
        logic [DW-1:0] exps [3];
        ops  = '{5'd3, 5'd4, 5'd5};
        exps = '{32'hD, 32'h1, 32'hC};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set1(1'b1, ops[i], 32'd5, 32'd9);
            else set1(1'b0, '0, '0, '0);
            #1;
            if (i < 3) begin
                n_checks++;
                if (Req1Ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: got %b expected 1", i, Req1Ready);
                end
            end
            cyc();
            if (i >= 1 && i <= 3) begin
                n_checks++;
                if ({Resp0Valid, Resp1Valid, RespResult} !== {1'b0, 1'b1, exps[i-1]}) begin
                    n_fail++;
                    $display("FAIL b2b_resp[%0d]: got r0=%b r1=%b res=%h expected 0 1 %h", i,
                             Resp0Valid, Resp1Valid, RespResult, exps[i-1]);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        set0(1'b1, 5'd0, 32'd1, 32'd1);
        cyc();
        Flush = 1'b1;
        #1;
        n_checks++;
        if ({Req0Ready, Req1Ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_ready: got %b%b expected 00", Req0Ready, Req1Ready);
        end
        cyc();
        idle();
        n_checks++;
        if ({Busy, Resp0Valid, Resp1Valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_squash: got busy=%b r0=%b r1=%b expected 0 0 0", Busy,
                     Resp0Valid, Resp1Valid);
        end
        set0(1'b1, 5'd0, 32'd2, 32'd2);
        set1(1'b1, 5'd0, 32'd3, 32'd3);
        #1;
        n_checks++;
        if ({Req0Ready, Req1Ready, Resp0Valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL flush_pointer: got ready=%b%b r0=%b expected 01 0", Req0Ready,
                     Req1Ready, Resp0Valid);
        end
        idle();
        cyc();
        cyc();
    endtask

    task automatic test_illegal();
        do_reset();
        set0(1'b1, 5'd30, 32'd1, 32'd1);
        cyc();
        idle();
        cyc();
        n_checks++;
        if ({Resp0Valid, RespError, RespResult, RespZero} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_resp: got r0=%b e=%b res=%h z=%b expected 1 1 0 1",
                     Resp0Valid, RespError, RespResult, RespZero);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        set0(1'b1, 5'd0, 32'd4, 32'd4);
        cyc();
        set0(1'b0, '0, '0, '0);
        set1(1'b1, 5'd3, 32'd6, 32'd1);
        cyc();
        idle();
        n_checks++;
        if ({Busy, Resp0Valid, AluControl} !== {1'b1, 1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL midop_setup: got busy=%b r0=%b ctl=%h expected 1 1 3", Busy,
                     Resp0Valid, AluControl);
        end
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({Resp0Valid, Resp1Valid, AluControl, AluA, AluB, Busy} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset: got r0=%b r1=%b ctl=%h a=%h b=%h busy=%b expected 0",
                     Resp0Valid, Resp1Valid, AluControl, AluA, AluB, Busy);
        end
        @(negedge Clk);
        Reset = 1'b0;
        set0(1'b1, 5'd0, 32'd1, 32'd2);
        set1(1'b1, 5'd0, 32'd3, 32'd4);
        #1;
        n_checks++;
        if ({Req0Ready, Req1Ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL midop_first_grant: got %b%b expected 10", Req0Ready, Req1Ready);
        end
        idle();
        cyc();
        n_checks++;
        if ({Resp0Valid, Resp1Valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midop_no_resp: got %b%b expected 00", Resp0Valid, Resp1Valid);
        end
    endtask

    typedef struct {
        bit            src;
        logic [DW-1:0] res;
        bit            zero;
        bit            err;
        int            due;
    } exp_t;

    task automatic test_random();
        exp_t          q[$];
        exp_t          e;
        bit            v0, v1, p0, p1, fl, g0, g1, ptr, popped, err;
        logic [CW-1:0] c0, c1, cw;
        logic [DW-1:0] a0, a1, b0, b1, aw, bw, res;
        logic [DW-1:0] last_res;
        bit            last_zero, last_err;
        do_reset();
        ptr = 0; p0 = 0; p1 = 0;
        last_res = '0; last_zero = 0; last_err = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p0) begin
                v0 = $urandom_range(0, 2) != 0; c0 = CW'($urandom_range(0, 31));
                a0 = DW'($urandom_range(0, 20)); b0 = DW'($urandom_range(0, 20));
            end
            if (!p1) begin
                v1 = $urandom_range(0, 2) != 0; c1 = CW'($urandom_range(0, 31));
                a1 = DW'($urandom_range(0, 20)); b1 = DW'($urandom_range(0, 20));
            end
            fl = $urandom_range(0, 15) == 0;
            set0(v0, c0, a0, b0);
            set1(v1, c1, a1, b1);
            Flush = fl;
            #1;
            g0 = !fl && v0 && (!v1 || ptr == 0);
            g1 = !fl && v1 && (!v0 || ptr == 1);
            n_checks++;
            if ({Req0Ready, Req1Ready} !== {g0, g1}) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got %b%b expected %b%b", n, Req0Ready,
                         Req1Ready, g0, g1);
            end
            p0 = v0 && !g0;
            p1 = v1 && !g1;
            cyc();
            if (fl) q.delete();
            popped = 0;
            if (q.size() > 0 && q[0].due == n) begin
                e = q.pop_front();
                popped = 1;
                last_res = e.res; last_zero = e.zero; last_err = e.err;
            end
            n_checks++;
            if ({Resp0Valid, Resp1Valid, RespResult, RespZero, RespError} !==
                {popped && !e.src, popped && e.src, last_res, last_zero, last_err}) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: got r0=%b r1=%b res=%h z=%b e=%b expected %b %b %h %b %b",
                         n, Resp0Valid, Resp1Valid, RespResult, RespZero, RespError,
                         popped && !e.src, popped && e.src, last_res, last_zero, last_err);
            end
            if (g0 || g1) begin
                cw = g1 ? c1 : c0; aw = g1 ? a1 : a0; bw = g1 ? b1 : b0;
                err = cw > CW'(MAXC);
                res = err ? '0 : alu_f(cw, aw, bw);
                q.push_back('{src: g1, res: res, zero: err || res == '0, err: err, due: n + 1});
                ptr = g0;
            end
            n_checks++;
            if (Busy !== (q.size() > 0 || popped)) begin
                n_fail++;
                $display("FAIL rand_busy[%0d]: got %b expected %b", n, Busy,
                         q.size() > 0 || popped);
            end
        end
        idle();
        cyc();
        cyc();
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        test_reset();
        test_single();
        test_alternate();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
